// File: rtl/pulse_sync_tx.sv
// pulse_sync_tx
//   Source-side transmitter for a req/ack level handshake. It carries single-cycle
//   events from the clksrc domain into another clock domain. Incoming event pulses
//   are counted. Each counted event launches one full 4-phase handshake on
//   req_clksrc: req rises, ack rises, req falls, then ack falls. ack_sync must
//   already be synchronized into clksrc by an external 2-FF stage.
//
// Parameters
//   CNT_W        width of the pending-event counter (at most 2**CNT_W-1 queued)
//   TIMEOUT_CYC  maximum number of cycles req may stay high without ack; 0 disables
//
// Ports
//   clksrc        clock
//   rst_clksrc    synchronous active-high reset
//   pulse_clksrc  one-cycle event to transfer, any density
//   ack_sync      destination ack level, already synchronized into clksrc
//   clr_err       clears the sticky overflow and timeout_err flags
//   req_clksrc    registered request level toward the destination sync chain
//   done_pulse    one-cycle pulse when a handshake completes
//   busy          handshake in flight or events still queued
//   pending_cnt   queued events not yet launched
//   overflow      sticky: an event was dropped because the counter was full
//   timeout_err   sticky: ack did not arrive within TIMEOUT_CYC cycles

module pulse_sync_tx #(
  parameter int CNT_W       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clksrc,
  input  logic             rst_clksrc,
  input  logic             pulse_clksrc,
  input  logic             ack_sync,
  input  logic             clr_err,
  output logic             req_clksrc,
  output logic             done_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             overflow,
  output logic             timeout_err
);

  // The timer only has to reach TIMEOUT_CYC-1 before the handshake is abandoned.
  localparam int                TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit                TMO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [TMR_W-1:0]  TMR_LAST = (TIMEOUT_CYC > 0) ? TMR_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACK_HI = 2'd1,
    WAIT_ACK_LO = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic               done_q, done_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               tmo_q, tmo_d;
  logic               launch;
  logic               ovf_set;
  logic               tmo_set;

  // Handshake sequencing. A launch in IDLE needs a low ack. This keeps a stale
  // ack (left high by a reset or a timeout) from being taken as the answer to a
  // new request. A timed-out handshake still waits for ack to go low before it
  // returns to IDLE, so the 4-phase protocol stays intact.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    done_d  = 1'b0;
    timer_d = timer_q;
    tmo_set = 1'b0;
    launch  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (((cnt_q != '0) || pulse_clksrc) && !ack_sync) begin
          launch  = 1'b1;
          req_d   = 1'b1;
          timer_d = '0;
          state_d = WAIT_ACK_HI;
        end
      end
      WAIT_ACK_HI: begin
        if (ack_sync) begin
          req_d   = 1'b0;
          state_d = WAIT_ACK_LO;
        end else if (TMO_EN && (timer_q == TMR_LAST)) begin
          req_d   = 1'b0;
          tmo_set = 1'b1;
          state_d = WAIT_ACK_LO;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      WAIT_ACK_LO: begin
        if (!ack_sync) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Pending-event bookkeeping. A pulse that launches directly from IDLE with an
  // empty queue never enters the counter. A pulse that arrives while the counter
  // is full, and with no launch to free a slot, is dropped and flagged.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    if (pulse_clksrc && !launch) begin
      if (cnt_q == CNT_MAX) begin
        ovf_set = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!pulse_clksrc && launch) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Sticky error flags. If a new error and clr_err arrive in the same cycle,
  // the new error wins, so no error is ever lost.
  always_comb begin
    ovf_d = ovf_set | (ovf_q & ~clr_err);
    tmo_d = tmo_set | (tmo_q & ~clr_err);
  end

  // All state registers. Reset also discards queued events and drops any
  // request that is in flight.
  always_ff @(posedge clksrc) begin
    if (rst_clksrc) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      timer_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      done_q  <= done_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  assign req_clksrc  = req_q;
  assign done_pulse  = done_q;
  assign busy        = (state_q != IDLE) || (cnt_q != '0);
  assign pending_cnt = cnt_q;
  assign overflow    = ovf_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_pulse_sync_tx.sv
// tb_pulse_sync_tx
//   Directed bench for pulse_sync_tx with two instances:
//   - A: CNT_W=4, TIMEOUT_CYC=16
//   - B: CNT_W=2, TIMEOUT_CYC=0
//   Each instance has an ack model. The model either mirrors req after a 3-cycle
//   delay or forces ack high or low. Every expected handshake is queued when it
//   is stimulated. The queue is popped when done_pulse appears.

module tb_pulse_sync_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic       rstA = 1'b1, pulseA = 1'b0, clrA = 1'b0, ackA;
  logic       reqA, doneA, busyA, ovfA, toA;
  logic [3:0] cntA;

  // Instance B signals
  logic       rstB = 1'b1, pulseB = 1'b0, clrB = 1'b0, ackB;
  logic       reqB, doneB, busyB, ovfB, toB;
  logic [1:0] cntB;

  pulse_sync_tx #(.CNT_W(4), .TIMEOUT_CYC(16)) dutA (
    .clksrc(clk), .rst_clksrc(rstA), .pulse_clksrc(pulseA), .ack_sync(ackA),
    .clr_err(clrA), .req_clksrc(reqA), .done_pulse(doneA), .busy(busyA),
    .pending_cnt(cntA), .overflow(ovfA), .timeout_err(toA)
  );

  pulse_sync_tx #(.CNT_W(2), .TIMEOUT_CYC(0)) dutB (
    .clksrc(clk), .rst_clksrc(rstB), .pulse_clksrc(pulseB), .ack_sync(ackB),
    .clr_err(clrB), .req_clksrc(reqB), .done_pulse(doneB), .busy(busyB),
    .pending_cnt(cntB), .overflow(ovfB), .timeout_err(toB)
  );

  // Ack models. Mode 0 follows req after a 3-cycle delay, mode 1 forces ack
  // high, mode 2 forces ack low.
  int ackModeA = 2, ackModeB = 2;
  logic [2:0] histA = '0, histB = '0;

  always @(posedge clk) begin
    histA <= {histA[1:0], reqA};
    histB <= {histB[1:0], reqB};
  end

  assign ackA = (ackModeA == 1) ? 1'b1 : (ackModeA == 2) ? 1'b0 : histA[2];
  assign ackB = (ackModeB == 1) ? 1'b1 : (ackModeB == 2) ? 1'b0 : histB[2];

  int total = 0;
  int bad = 0;
  int qA[$];
  int qB[$];
  int pushA = 0, pushB = 0;
  int doneSeenA = 0, doneSeenB = 0;
  int peakA = 0;
  int hiCycles;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit useB, input logic p, input logic clr);
    if (useB) begin
      pulseB = p;
      clrB = clr;
    end else begin
      pulseA = p;
      clrA = clr;
    end
    tick();
    pulseA = 1'b0;
    clrA = 1'b0;
    pulseB = 1'b0;
    clrB = 1'b0;
  endtask

  task automatic expectHandshake(input bit useB);
    if (useB) begin
      qB.push_back(pushB);
      pushB++;
    end else begin
      qA.push_back(pushA);
      pushA++;
    end
  endtask

  task automatic waitIdle(input bit useB, input int budget, input string tag);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < budget; i++) begin
      idle = useB ? (!busyB && qB.size() == 0) : (!busyA && qA.size() == 0);
      if (idle) break;
      tick();
    end
    checkOutput(tag, 32'(idle), 32'd1);
  endtask

  // Completion monitor. It samples on the falling edge, in the middle of each
  // cycle, and matches every done_pulse to the oldest outstanding expectation.
  always @(negedge clk) begin
    if (doneA === 1'b1) begin
      checkOutput("doneExpectedA", 32'(qA.size() > 0), 32'd1);
      if (qA.size() > 0) checkOutput("doneOrderA", 32'(doneSeenA), 32'(qA.pop_front()));
      doneSeenA++;
    end
    if (doneB === 1'b1) begin
      checkOutput("doneExpectedB", 32'(qB.size() > 0), 32'd1);
      if (qB.size() > 0) checkOutput("doneOrderB", 32'(doneSeenB), 32'(qB.pop_front()));
      doneSeenB++;
    end
    if (int'(cntA) > peakA) peakA = int'(cntA);
  end

  initial begin
    $display("[TB] start");
    // Reset both instances
    repeat (4) tick();
    rstA = 1'b0;
    rstB = 1'b0;
    checkOutput("rstReqA", 32'(reqA), 0);
    checkOutput("rstDoneA", 32'(doneA), 0);
    checkOutput("rstBusyA", 32'(busyA), 0);
    checkOutput("rstCntA", 32'(cntA), 0);
    checkOutput("rstOvfA", 32'(ovfA), 0);
    checkOutput("rstToA", 32'(toA), 0);
    checkOutput("rstReqB", 32'(reqB), 0);
    checkOutput("rstCntB", 32'(cntB), 0);
    ackModeA = 0;
    ackModeB = 0;
    tick();

    // Single pulse: req follows one cycle later, then one completion
    expectHandshake(0);
    applyStimulus(0, 1'b1, 1'b0);
    checkOutput("t1ReqLatency", 32'(reqA), 1);
    checkOutput("t1Busy", 32'(busyA), 1);
    waitIdle(0, 100, "t1Idle");
    checkOutput("t1Cnt", 32'(cntA), 0);
    checkOutput("t1Busy0", 32'(busyA), 0);

    // Five back-to-back pulses
    tick();
    peakA = 0;
    repeat (5) expectHandshake(0);
    repeat (5) applyStimulus(0, 1'b1, 1'b0);
    waitIdle(0, 400, "t2Idle");
    checkOutput("t2Peak", 32'(peakA), 4);
    checkOutput("t2Ovf", 32'(ovfA), 0);
    checkOutput("t2Dones", 32'(doneSeenA), 6);

    // Stale ack blocks launch; then a pulse coincides with an IDLE launch at cnt=1
    tick();
    ackModeA = 1;
    repeat (2) expectHandshake(0);
    applyStimulus(0, 1'b1, 1'b0);
    checkOutput("t6BlockedCnt", 32'(cntA), 1);
    checkOutput("t6BlockedReq", 32'(reqA), 0);
    ackModeA = 0;
    applyStimulus(0, 1'b1, 1'b0);
    checkOutput("t6CoincCnt", 32'(cntA), 1);
    checkOutput("t6CoincReq", 32'(reqA), 1);
    waitIdle(0, 200, "t6Idle");
    checkOutput("t6Dones", 32'(doneSeenA), 8);

    // Timeout: ack held low, req must stay high exactly 16 cycles
    tick();
    ackModeA = 2;
    expectHandshake(0);
    applyStimulus(0, 1'b1, 1'b0);
    hiCycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (reqA !== 1'b1) break;
      hiCycles++;
      tick();
    end
    checkOutput("t4ReqHighCycles", 32'(hiCycles), 16);
    checkOutput("t4TimeoutErr", 32'(toA), 1);
    waitIdle(0, 50, "t4Idle");
    applyStimulus(0, 1'b0, 1'b1);
    checkOutput("t4Cleared", 32'(toA), 0);

    // Reset while waiting for ack with two events queued
    ackModeA = 0;
    tick();
    repeat (3) applyStimulus(0, 1'b1, 1'b0);
    checkOutput("t5PreCnt", 32'(cntA), 2);
    checkOutput("t5PreReq", 32'(reqA), 1);
    ackModeA = 1;
    rstA = 1'b1;
    tick();
    rstA = 1'b0;
    checkOutput("t5RstReq", 32'(reqA), 0);
    checkOutput("t5RstCnt", 32'(cntA), 0);
    checkOutput("t5RstBusy", 32'(busyA), 0);
    expectHandshake(0);
    applyStimulus(0, 1'b1, 1'b0);
    repeat (3) tick();
    checkOutput("t5StaleAckReq", 32'(reqA), 0);
    checkOutput("t5StaleAckCnt", 32'(cntA), 1);
    ackModeA = 0;
    waitIdle(0, 100, "t5Idle");
    checkOutput("t5Dones", 32'(doneSeenA), 10);

    // Small counter: one launch, ack stalls high, then six pulses in total
    repeat (4) expectHandshake(1);
    applyStimulus(1, 1'b1, 1'b0);
    ackModeB = 1;
    repeat (5) applyStimulus(1, 1'b1, 1'b0);
    checkOutput("t3Ovf", 32'(ovfB), 1);
    checkOutput("t3Cnt", 32'(cntB), 3);
    checkOutput("t3ReqLow", 32'(reqB), 0);
    applyStimulus(1, 1'b1, 1'b1);
    checkOutput("t6OvfWinsClr", 32'(ovfB), 1);
    checkOutput("t6CntHeld", 32'(cntB), 3);
    applyStimulus(1, 1'b0, 1'b1);
    checkOutput("t6OvfCleared", 32'(ovfB), 0);
    ackModeB = 0;
    waitIdle(1, 400, "t3Idle");
    checkOutput("t3Dones", 32'(doneSeenB), 4);
    checkOutput("t3CntEnd", 32'(cntB), 0);
    checkOutput("t3ToB", 32'(toB), 0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
